// File: rtl/nios_sys_pio_in_edge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios_sys_pio_pkg
//  Description : Shared constants and types for the Nios II edge-capturing
//                input PIO: register word addresses and edge-type encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package nios_sys_pio_pkg;

    // Avalon-MM word addresses of the register map
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RESERVED = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    // Capture condition selected by the EDGE_TYPE parameter
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage
`default_nettype wire

// File: rtl/nios_sys_pio_in_edge_if.sv
`default_nettype none
// ============================================================================
//  Module      : nios_sys_pio_in_edge_if
//  Description : Avalon-MM slave bus bundle for the input PIO.
//                master : address, chipselect, write_n, writedata -> ; <- readdata
//                slave  : mirror image of master
//  Revision    : 1.0  initial release
// ============================================================================
interface nios_sys_pio_in_edge_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface
`default_nettype wire

// File: rtl/nios_sys_pio_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : nios_sys_pio_debounce
//  Description : One-bit input conditioner: SYNC_STAGES-deep synchroniser,
//                optionally followed by a stability-window debouncer.
//                Optional feature macro: NIOS_SYS_PIO_DEBOUNCE_EN
//                  defined   -> output follows the synchronised input only
//                               after DEBOUNCE_CYCLES consecutive differing
//                               cycles
//                  undefined -> output is the last synchroniser stage
//  Ports       : clk      system clock
//                reset_n  asynchronous active-low reset
//                i_in     asynchronous external input bit
//                o_cond   conditioned input bit
//  Revision    : 1.0  initial release
// ============================================================================
module nios_sys_pio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_in,
    output logic      o_cond
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

`ifdef NIOS_SYS_PIO_DEBOUNCE_EN
    localparam int             CW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_cond;

    // The counter measures how long the synchronised input has disagreed
    // with the accepted value; any agreement restarts the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_cond <= 1'b0;
        end else if (w_s == r_cond) begin
            r_cnt  <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cond <= w_s;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_cond = r_cond;
`else
    localparam int c_unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign o_cond = w_s;
`endif

endmodule
`default_nettype wire

// File: rtl/nios_sys_pio_in_edge.sv
`default_nettype none
// ============================================================================
//  Module      : nios_sys_pio_in_edge
//  Description : Parametrised Avalon-MM input PIO with per-bit edge capture
//                and maskable level interrupt.
//                Optional feature macro: NIOS_SYS_PIO_DEBOUNCE_EN (per-bit
//                debouncer between synchroniser and edge detector).
//  Ports       : clk      system clock
//                reset_n  asynchronous active-low reset
//                bus      Avalon-MM slave (address/chipselect/write_n/
//                         writedata in, registered readdata out)
//                in_port  WIDTH asynchronous external inputs
//                irq      registered level interrupt
//  Registers   : 0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAP (RW1C)
//  Revision    : 1.0  initial release
// ============================================================================
module nios_sys_pio_in_edge
    import nios_sys_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    nios_sys_pio_in_edge_if.slave     bus,
    input  wire logic [WIDTH-1:0]     in_port,
    output logic                      irq
);

    logic [WIDTH-1:0] w_cond;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rdata;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;

    // ------------------------------------------------------------------
    // Per-bit input conditioning
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            nios_sys_pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cond (
                .clk     (clk),
                .reset_n (reset_n),
                .i_in    (in_port[gi]),
                .o_cond  (w_cond[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge event selection
    // ------------------------------------------------------------------
    generate
        if (EDGE_TYPE == int'(EDGE_RISE)) begin : g_rise
            assign w_edge = w_cond & ~r_prev;
        end else if (EDGE_TYPE == int'(EDGE_FALL)) begin : g_fall
            assign w_edge = ~w_cond & r_prev;
        end else begin : g_any
            assign w_edge = w_cond ^ r_prev;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_wr  = bus.chipselect & ~bus.write_n;
    assign w_clr = (w_wr && (bus.address == ADDR_EDGECAP)) ? bus.writedata[WIDTH-1:0]
                                                           : '0;

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = &{1'b0, bus.writedata[31:WIDTH]};
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_DATA:    w_rdata[WIDTH-1:0] = w_cond;
            ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edgecap;
            default:      w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_readdata <= '0;
            irq        <= 1'b0;
        end else begin
            r_prev <= w_cond;
            if (w_wr && (bus.address == ADDR_IRQMASK)) begin
                r_irqmask <= bus.writedata[WIDTH-1:0];
            end
            // The edge term is OR-ed in after the clear so a new edge in
            // the same cycle as a software clear is never lost.
            r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
            irq        <= |(r_edgecap & r_irqmask);
            r_readdata <= w_rdata;
        end
    end

    assign bus.readdata = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_nios_sys_pio_in_edge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios_sys_pio_in_edge
//  Description : Self-checking bench for nios_sys_pio_in_edge. Three DUTs
//                (rising, falling, any edge) share one stimulus stream and
//                are compared every cycle with a behavioural model, plus
//                directed checks of the documented latencies and corner
//                cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nios_sys_pio_in_edge;
    import nios_sys_pio_pkg::*;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int DC    = 16;
`ifdef NIOS_SYS_PIO_DEBOUNCE_EN
    localparam int EXTRA = DC;
`else
    localparam int EXTRA = 0;
`endif

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       address    = 2'd0;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic [31:0]      writedata  = '0;
    logic [WIDTH-1:0] in_port    = '0;
    logic             irq_r, irq_f, irq_a;

    always #5 clk = ~clk;

    nios_sys_pio_in_edge_if bus_r ();
    nios_sys_pio_in_edge_if bus_f ();
    nios_sys_pio_in_edge_if bus_a ();

    assign bus_r.address = address;  assign bus_r.chipselect = chipselect;
    assign bus_r.write_n = write_n;  assign bus_r.writedata  = writedata;
    assign bus_f.address = address;  assign bus_f.chipselect = chipselect;
    assign bus_f.write_n = write_n;  assign bus_f.writedata  = writedata;
    assign bus_a.address = address;  assign bus_a.chipselect = chipselect;
    assign bus_a.write_n = write_n;  assign bus_a.writedata  = writedata;

    nios_sys_pio_in_edge #(.WIDTH(WIDTH), .EDGE_TYPE(0), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC))
        u_rise (.clk(clk), .reset_n(reset_n), .bus(bus_r), .in_port(in_port), .irq(irq_r));
    nios_sys_pio_in_edge #(.WIDTH(WIDTH), .EDGE_TYPE(1), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC))
        u_fall (.clk(clk), .reset_n(reset_n), .bus(bus_f), .in_port(in_port), .irq(irq_f));
    nios_sys_pio_in_edge #(.WIDTH(WIDTH), .EDGE_TYPE(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC))
        u_any  (.clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_port), .irq(irq_a));

    // ------------------------------------------------------------------
    // Behavioural model. Index 0/1/2 = rising/falling/any DUT.
    // in_q holds past in_port samples, newest first.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] in_q[$];
    logic [WIDTH-1:0] m_cond = '0;
    logic [WIDTH-1:0] m_prev = '0;
    logic [WIDTH-1:0] m_mask = '0;
    logic [WIDTH-1:0] m_cap [3];
    logic [31:0]      m_rd  [3];
    logic             m_irq [3];
    int               m_run [WIDTH];

    initial begin
        for (int t = 0; t < 3; t++) begin
            m_cap[t] = '0; m_rd[t] = '0; m_irq[t] = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    end

    function automatic logic [WIDTH-1:0] sync_out();
        return (in_q.size() >= SYNC) ? in_q[SYNC-1] : '0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic [WIDTH-1:0] ev [3];
        logic [WIDTH-1:0] clr;
        logic [WIDTH-1:0] s_old;
        logic [WIDTH-1:0] s_new;
        logic             wr;
        if (!reset_n) begin
            in_q.delete();
            m_cond = '0; m_prev = '0; m_mask = '0;
            for (int t = 0; t < 3; t++) begin
                m_cap[t] = '0; m_rd[t] = '0; m_irq[t] = 1'b0;
            end
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
        end else begin
            ev[0] = m_cond & ~m_prev;
            ev[1] = ~m_cond & m_prev;
            ev[2] = m_cond ^ m_prev;
            wr    = chipselect && !write_n;
            clr   = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
            for (int t = 0; t < 3; t++) begin
                m_irq[t] = |(m_cap[t] & m_mask);
                case (address)
                    2'd0:    m_rd[t] = 32'(m_cond);
                    2'd2:    m_rd[t] = 32'(m_mask);
                    2'd3:    m_rd[t] = 32'(m_cap[t]);
                    default: m_rd[t] = 32'd0;
                endcase
                m_cap[t] = (m_cap[t] & ~clr) | ev[t];
            end
            if (wr && address == 2'd2) m_mask = writedata[WIDTH-1:0];
            s_old = sync_out();
            in_q.push_front(in_port);
            if (in_q.size() > SYNC) void'(in_q.pop_back());
            s_new = sync_out();
            m_prev = m_cond;
`ifdef NIOS_SYS_PIO_DEBOUNCE_EN
            for (int i = 0; i < WIDTH; i++) begin
                if (s_old[i] != m_cond[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_cond[i] = s_old[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
`else
            m_cond = s_new;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("rd_rise",  bus_r.readdata, m_rd[0]);
        chk("rd_fall",  bus_f.readdata, m_rd[1]);
        chk("rd_any",   bus_a.readdata, m_rd[2]);
        chk("irq_rise", 32'(irq_r), 32'(m_irq[0]));
        chk("irq_fall", 32'(irq_f), 32'(m_irq[1]));
        chk("irq_any",  32'(irq_a), 32'(m_irq[2]));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed and random sequence
    // ------------------------------------------------------------------
    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_rd",  bus_r.readdata, 32'h0);
        chk("reset_irq", 32'(irq_a), 32'h0);
        reset_n = 1'b1;
        settle(2);

        // DATA read latency
        in_port = 8'hA5; address = 2'd0;
        n = 0;
        while (bus_r.readdata !== 32'h0000_00A5 && n < SYNC + 2 + EXTRA) begin
            step(); n++;
        end
        chk("data_latency", n, 3 + EXTRA);
        chk("data_value", bus_r.readdata, 32'h0000_00A5);

        // Quiesce and clear captures
        in_port = 8'h00;
        settle(6 + EXTRA);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        settle(2);

        // Rising edge on bit 0 with mask bit 0
        bus_wr(2'd2, 32'h0000_0001);
        in_port = 8'h01;
        n = 0;
        while (irq_r !== 1'b1 && n < 40 + EXTRA) begin
            step(); n++;
        end
        chk("irq_latency", n, 4 + EXTRA);
        address = 2'd3;
        step();
        chk("edgecap_b0", bus_r.readdata, 32'h1);
        bus_wr(2'd3, 32'h0000_0001);
        chk("irq_hold_after_clr", 32'(irq_r), 32'h1);
        step();
        chk("irq_drop_after_clr", 32'(irq_r), 32'h0);
        chk("edgecap_cleared", bus_r.readdata, 32'h0);

        // Same-cycle edge and clear on bit 3 (any-edge DUT keeps the bit)
        in_port = 8'h09;
        settle(6 + EXTRA);
        address = 2'd3;
        step();
        chk("any_rise_b3", 32'(bus_a.readdata[3]), 32'h1);
        in_port = 8'h01;
        settle(2 + EXTRA);
        bus_wr(2'd3, 32'h0000_0008);
        step();
        chk("any_setwins_b3",  32'(bus_a.readdata[3]), 32'h1);
        chk("fall_setwins_b3", 32'(bus_f.readdata[3]), 32'h1);
        chk("rise_cleared_b3", 32'(bus_r.readdata[3]), 32'h0);

        // Masked capture, then unmask
        bus_wr(2'd2, 32'h0);
        bus_wr(2'd3, 32'hFF);
        step();
        in_port = 8'h05;
        settle(6 + EXTRA);
        address = 2'd3;
        step();
        chk("masked_cap", bus_r.readdata, 32'h4);
        chk("masked_irq", 32'(irq_r), 32'h0);
        bus_wr(2'd2, 32'h0000_0004);
        chk("unmask_irq_same", 32'(irq_r), 32'h0);
        step();
        chk("unmask_irq_next", 32'(irq_r), 32'h1);

`ifdef NIOS_SYS_PIO_DEBOUNCE_EN
        // Glitch rejection then a stable level on bit 1
        bus_wr(2'd3, 32'hFF);
        in_port[1] = 1'b1;
        settle(10);
        in_port[1] = 1'b0;
        address = 2'd0;
        settle(DC + 8);
        chk("glitch_data", 32'(bus_r.readdata[1]), 32'h0);
        address = 2'd3;
        step();
        chk("glitch_cap", 32'(bus_r.readdata[1]), 32'h0);
        address = 2'd0;
        in_port[1] = 1'b1;
        settle(20);
        chk("level_data", 32'(bus_r.readdata[1]), 32'h1);
        address = 2'd3;
        settle(2);
        chk("level_cap", 32'(bus_r.readdata[1]), 32'h1);
`endif

        // Randomised traffic against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) in_port = WIDTH'($urandom);
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 2) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            writedata  = $urandom;
            step();
        end
        chipselect = 1'b0; write_n = 1'b1;

        // Asynchronous reset while captures and irq are active
        bus_wr(2'd2, 32'hFF);
        in_port = ~in_port;
        settle(6 + EXTRA);
        address = 2'd3;
        step();
        chk("pre_reset_cap", bus_a.readdata, 32'hFF);
        chk("pre_reset_irq", 32'(irq_a), 32'h1);
        in_port = 8'h00;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rd",  bus_a.readdata, 32'h0);
        chk("async_irq", 32'(irq_a), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        address = 2'd2;
        step();
        chk("post_reset_mask", bus_a.readdata, 32'h0);
        address = 2'd3;
        step();
        chk("post_reset_cap", bus_a.readdata, 32'h0);
        settle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
